// File: rtl/usb_pkg.sv
// Shared USB definitions: descriptor type codes, EP0 packet size, EP0 FSM states.
package usb_pkg;

  localparam logic [7:0] DESC_DEVICE     = 8'h01;
  localparam logic [7:0] DESC_CONFIG     = 8'h02;
  localparam logic [7:0] DESC_STRING     = 8'h03;
  localparam logic [7:0] DESC_HID_REPORT = 8'h22;

  localparam int EP0_MAX_PKT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT_IN,
    ST_SEND,
    ST_EOP,
    ST_WAIT_ACK,
    ST_STALL
  } ep0_state_e;

endpackage

// File: rtl/usb_ep0_desc_streamer.sv
// EP0 GET_DESCRIPTOR data stage: walks the descriptor ROM and feeds the packet
// transmitter up to MAX_PKT bytes per IN token, with DATA0/1 toggling,
// short-packet/ZLP termination, retransmit on missing ACK and STALL on
// unknown descriptors.
module usb_ep0_desc_streamer
  import usb_pkg::*;
#(
  parameter int MAX_PKT = EP0_MAX_PKT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  req_type,
  input  logic [7:0]  req_index,
  input  logic [15:0] req_length,
  input  logic        in_token,
  input  logic        ack_rx,
  input  logic        ack_timeout,
  output logic [7:0]  rom_type,
  output logic [7:0]  rom_index,
  output logic [15:0] rom_byte_index,
  output logic [15:0] rom_req_len,
  input  logic [7:0]  rom_data,
  input  logic        rom_valid,
  output logic        tx_start,
  output logic        tx_pid_data1,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_eop,
  output logic        tx_stall,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_PKT);

  ep0_state_e  state_q, state_d;
  logic [15:0] offset_q, offset_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        toggle_q, toggle_d;
  logic [7:0]  type_q, type_d;
  logic [7:0]  index_q, index_d;
  logic [15:0] len_q, len_d;
  logic        tx_start_q, tx_start_d;
  logic        done_q, done_d;

  logic [16:0] sum;
  logic [15:0] byte_idx;
  logic        can_send;

  // offset+cnt, saturated to 16 bits; doubles as the post-ACK offset
  always_comb begin
    sum      = {1'b0, offset_q} + {13'd0, cnt_q};
    byte_idx = sum[16] ? 16'hFFFF : sum[15:0];
    can_send = rom_valid && (cnt_q < MAX_CNT);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      offset_q   <= '0;
      cnt_q      <= '0;
      toggle_q   <= 1'b1;
      type_q     <= '0;
      index_q    <= '0;
      len_q      <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      cnt_q      <= cnt_d;
      toggle_q   <= toggle_d;
      type_q     <= type_d;
      index_q    <= index_d;
      len_q      <= len_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; a new SETUP preempts everything, including a packet in flight
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    cnt_d      = cnt_q;
    toggle_d   = toggle_q;
    type_d     = type_q;
    index_d    = index_q;
    len_d      = len_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    if (start) begin
      type_d   = req_type;
      index_d  = req_index;
      len_d    = req_length;
      offset_d = '0;
      cnt_d    = '0;
      toggle_d = 1'b1;
      state_d  = ST_CHECK;
    end else begin
      case (state_q)
        ST_CHECK: begin
          if (len_q == 16'd0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (!rom_valid) begin
            state_d = ST_STALL;
          end else begin
            state_d = ST_WAIT_IN;
          end
        end
        ST_WAIT_IN: begin
          if (in_token) begin
            tx_start_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_SEND;
          end
        end
        ST_SEND: begin
          // the tx_start cycle carries no payload
          if (!tx_start_q) begin
            if (can_send) begin
              if (tx_ready) begin
                cnt_d = cnt_q + 4'd1;
                // full packet: go straight to EOP without an idle probe cycle
                if (cnt_q + 4'd1 == MAX_CNT) state_d = ST_EOP;
              end
            end else begin
              state_d = ST_EOP;
            end
          end
        end
        ST_EOP: state_d = ST_WAIT_ACK;
        ST_WAIT_ACK: begin
          if (ack_rx) begin
            offset_d = byte_idx;
            toggle_d = ~toggle_q;
            if (cnt_q < MAX_CNT || byte_idx == len_q) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_WAIT_IN;
            end
          end else if (in_token) begin
            // host lost our packet and retried: resend from the same offset
            tx_start_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_SEND;
          end else if (ack_timeout) begin
            state_d = ST_WAIT_IN;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    rom_type       = type_q;
    rom_index      = index_q;
    rom_req_len    = len_q;
    rom_byte_index = (state_q == ST_SEND) ? byte_idx : offset_q;
    tx_start       = tx_start_q;
    tx_valid       = (state_q == ST_SEND) && !tx_start_q && can_send;
    tx_data        = tx_valid ? rom_data : 8'h00;
    tx_eop         = (state_q == ST_EOP);
    tx_pid_data1   = toggle_q && (state_q == ST_SEND || state_q == ST_EOP);
    tx_stall       = (state_q == ST_STALL);
    busy           = (state_q != ST_IDLE) && (state_q != ST_STALL);
    done           = done_q;
  end

endmodule

// File: tb/tb_usb_ep0_desc_streamer.sv
// Bench for usb_ep0_desc_streamer: behavioural descriptor ROM, scoreboard of
// expected transmitter events filled by the stimulus, independent monitor.
module tb_usb_ep0_desc_streamer;
  import usb_pkg::*;

  localparam int MP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  req_type = '0;
  logic [7:0]  req_index = '0;
  logic [15:0] req_length = '0;
  logic        in_token = 1'b0;
  logic        ack_rx = 1'b0;
  logic        ack_timeout = 1'b0;
  logic [7:0]  rom_type, rom_index;
  logic [15:0] rom_byte_index, rom_req_len;
  logic [7:0]  rom_data;
  logic        rom_valid;
  logic        tx_start, tx_pid_data1, tx_valid, tx_eop, tx_stall, busy, done;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  usb_ep0_desc_streamer #(.MAX_PKT(MP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_type(req_type),
    .req_index(req_index), .req_length(req_length), .in_token(in_token),
    .ack_rx(ack_rx), .ack_timeout(ack_timeout), .rom_type(rom_type),
    .rom_index(rom_index), .rom_byte_index(rom_byte_index),
    .rom_req_len(rom_req_len), .rom_data(rom_data), .rom_valid(rom_valid),
    .tx_start(tx_start), .tx_pid_data1(tx_pid_data1), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_eop(tx_eop),
    .tx_stall(tx_stall), .busy(busy), .done(done)
  );

  // ---------------- descriptor ROM model ----------------
  // device(18) config(34) hid report(52) string0(4) string1(8)
  logic [7:0] rom_mem [116];
  initial rom_mem = '{
    8'h12,8'h01,8'h00,8'h02,8'h00,8'h00,8'h00,8'h08,8'h34,8'h12,8'h78,8'h56,8'h00,8'h01,8'h01,8'h02,8'h00,8'h01,
    8'h09,8'h02,8'h22,8'h00,8'h01,8'h01,8'h00,8'h80,8'h32,
    8'h09,8'h04,8'h00,8'h00,8'h01,8'h03,8'h01,8'h02,8'h00,
    8'h09,8'h21,8'h11,8'h01,8'h00,8'h01,8'h22,8'h34,8'h00,
    8'h07,8'h05,8'h81,8'h03,8'h08,8'h00,8'h0A,
    8'h05,8'h01,8'h09,8'h02,8'hA1,8'h01,8'h09,8'h01,8'hA1,8'h00,8'h05,8'h09,8'h19,8'h01,8'h29,8'h03,
    8'h15,8'h00,8'h25,8'h01,8'h95,8'h03,8'h75,8'h01,8'h81,8'h02,8'h95,8'h01,8'h75,8'h05,8'h81,8'h01,
    8'h05,8'h01,8'h09,8'h30,8'h09,8'h31,8'h15,8'h81,8'h25,8'h7F,8'h75,8'h08,8'h95,8'h02,8'h81,8'h06,
    8'h09,8'h38,8'hC0,8'hC0,
    8'h04,8'h03,8'h09,8'h04,
    8'h08,8'h03,8'h55,8'h00,8'h53,8'h00,8'h42,8'h00
  };

  function automatic int desc_base(input logic [7:0] t, input logic [7:0] i);
    if (t == DESC_DEVICE && i == 8'd0) return 0;
    if (t == DESC_CONFIG && i == 8'd0) return 18;
    if (t == DESC_HID_REPORT && i == 8'd0) return 52;
    if (t == DESC_STRING && i == 8'd0) return 104;
    if (t == DESC_STRING && i == 8'd1) return 108;
    return -1;
  endfunction

  function automatic int desc_len(input logic [7:0] t, input logic [7:0] i);
    if (t == DESC_DEVICE && i == 8'd0) return 18;
    if (t == DESC_CONFIG && i == 8'd0) return 34;
    if (t == DESC_HID_REPORT && i == 8'd0) return 52;
    if (t == DESC_STRING && i == 8'd0) return 4;
    if (t == DESC_STRING && i == 8'd1) return 8;
    return 0;
  endfunction

  int rom_b, rom_l;
  // combinational ROM, clipped at descriptor length and requested length
  always_comb begin
    rom_valid = 1'b0;
    rom_data  = 8'h00;
    rom_b     = desc_base(rom_type, rom_index);
    rom_l     = desc_len(rom_type, rom_index);
    if (rom_b >= 0 && int'(rom_byte_index) < rom_l && rom_byte_index < rom_req_len) begin
      rom_valid = 1'b1;
      rom_data  = rom_mem[rom_b + int'(rom_byte_index)];
    end
  end

  // ---------------- scoreboard ----------------
  typedef enum int {EV_START, EV_BYTE, EV_EOP, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic expect_ev(input ev_kind_e k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input ev_kind_e k, input logic [7:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event got=%s/%02h required=none", k.name(), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        failures++;
        $display("FAIL event got=%s/%02h required=%s/%02h", k.name(), v, e.kind.name(), e.val);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // monitor: every transmitter event is popped and compared; backpressure stability checked
  logic       hold_prev = 1'b0, start_prev = 1'b0;
  logic [7:0] data_prev = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) got_ev(EV_START, {7'd0, tx_pid_data1});
      if (tx_valid && tx_ready) got_ev(EV_BYTE, tx_data);
      if (tx_eop) got_ev(EV_EOP, {7'd0, tx_pid_data1});
      if (done) got_ev(EV_DONE, 8'h00);
      if (hold_prev && !start_prev) begin
        checks++;
        if (!tx_valid || tx_data !== data_prev) begin
          failures++;
          $display("FAIL hold_stable got=%b/%02h required=1/%02h", tx_valid, tx_data, data_prev);
        end
      end
      hold_prev  = tx_valid && !tx_ready;
      data_prev  = tx_data;
      start_prev = start;
    end
  end

  // tx_ready driver: fixed level or 50% random
  bit rand_mode = 1'b0;
  bit ready_fix = 1'b1;
  always @(posedge clk) begin
    #1;
    tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [7:0] t, input logic [7:0] i, input logic [15:0] len);
    tick();
    start = 1'b1; req_type = t; req_index = i; req_length = len;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_in();
    tick();
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
  endtask

  task automatic pulse_ack(input bit timeout);
    tick();
    if (timeout) ack_timeout = 1'b1; else ack_rx = 1'b1;
    tick();
    ack_rx = 1'b0;
    ack_timeout = 1'b0;
  endtask

  task automatic wait_eop(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (tx_eop) begin
        ok = 1'b1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL eop_timeout got=no_eop required=eop");
  endtask

  task automatic push_pkt(input int base, input int off, input int n, input bit tog);
    expect_ev(EV_START, {7'd0, tog});
    for (int k = 0; k < n; k++) expect_ev(EV_BYTE, rom_mem[base + off + k]);
    expect_ev(EV_EOP, {7'd0, tog});
  endtask

  // full GET_DESCRIPTOR data stage; to_pkt = packet index answered with ack_timeout once
  task automatic transfer(input logic [7:0] t, input logic [7:0] i, input logic [15:0] len,
                          input int to_pkt, input bit rnd, output int npkt);
    int  total, off, n, base;
    bit  tog, fin, ok;
    base  = desc_base(t, i);
    total = desc_len(t, i);
    if (total > int'(len)) total = int'(len);
    npkt = 0; off = 0; tog = 1'b1; fin = 1'b0;
    if (len == 16'd0) expect_ev(EV_DONE, 8'h00);
    do_start(t, i, len);
    rand_mode = rnd;
    if (len == 16'd0) begin
      tick(4);
      return;
    end
    while (!fin) begin
      n = total - off;
      if (n > MP) n = MP;
      fin = (n < MP) || (off + n == int'(len));
      push_pkt(base, off, n, tog);
      pulse_in();
      wait_eop(ok);
      if (!ok) return;
      if (npkt == to_pkt) begin
        pulse_ack(1'b1);
        push_pkt(base, off, n, tog);
        pulse_in();
        wait_eop(ok);
        if (!ok) return;
      end
      if (fin) expect_ev(EV_DONE, 8'h00);
      pulse_ack(1'b0);
      off += n;
      tog = !tog;
      npkt++;
    end
    tick(3);
    rand_mode = 1'b0;
  endtask

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int np, hs;
    @(negedge clk);
    check("reset_outputs", {25'd0, tx_start, tx_valid, tx_eop, tx_stall, busy, done, tx_pid_data1}, 32'd0);
    check("reset_byte_index", {16'd0, rom_byte_index}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    transfer(DESC_DEVICE, 8'd0, 16'd64, -1, 1'b0, np);
    check("dev64_pkts", np, 3);
    transfer(DESC_DEVICE, 8'd0, 16'd8, -1, 1'b0, np);
    check("dev8_pkts", np, 1);
    transfer(DESC_DEVICE, 8'd0, 16'd16, -1, 1'b0, np);
    check("dev16_pkts", np, 2);
    transfer(DESC_DEVICE, 8'd0, 16'd0, -1, 1'b0, np);
    check("dev0_busy", {31'd0, busy}, 32'd0);
    transfer(DESC_HID_REPORT, 8'd0, 16'd255, -1, 1'b0, np);
    check("hid_pkts", np, 7);
    transfer(DESC_CONFIG, 8'd0, 16'd255, 1, 1'b0, np);
    check("cfg_pkts", np, 5);

    // unsupported type: stall, no packets even when IN tokens arrive
    do_start(8'h06, 8'd0, 16'd64);
    tick();
    @(negedge clk);
    check("stall_set", {31'd0, tx_stall}, 32'd1);
    check("stall_busy", {31'd0, busy}, 32'd0);
    pulse_in();
    pulse_in();
    check("stall_held", {31'd0, tx_stall}, 32'd1);
    transfer(DESC_STRING, 8'd0, 16'd255, -1, 1'b0, np);
    check("str0_pkts", np, 1);
    check("stall_cleared", {31'd0, tx_stall}, 32'd0);

    // abort mid-SEND under random backpressure, then restart the transfer
    do_start(DESC_STRING, 8'd1, 16'd255);
    rand_mode = 1'b1;
    expect_ev(EV_START, 8'h01);
    for (int k = 0; k < 3; k++) expect_ev(EV_BYTE, rom_mem[108 + k]);
    pulse_in();
    hs = 0;
    for (int c = 0; c < 400 && hs < 3; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) hs++;
    end
    check("abort_handshakes", hs, 3);
    ready_fix = 1'b0;
    rand_mode = 1'b0;
    transfer(DESC_STRING, 8'd1, 16'd255, -1, 1'b1, np);
    ready_fix = 1'b1;
    check("str1_pkts", np, 2);

    tick(4);
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_busy", {31'd0, busy}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
